predicate_init_engine: RTL and testbench

Sequencer that initializes every predicate register of one warp to a fill value across a selected set of lanes, then optionally reads each register back through read port 0 and reports mismatches. It sits between the warp scheduler (request side) and `predicate_register_block` (write port plus read port 0). It is used on warp launch and for predicate-file self-test.

---
 rtl/predicate_pkg.sv | 17 +
 rtl/predicate_init_engine.sv | 141 ++++++++++++++
 tb/tb_predicate_init_engine.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/predicate_pkg.sv
// Shared sizing and state encoding for the predicate-file init engine.
package predicate_pkg;

  localparam int unsigned NUM_LANES = 8;
  localparam int unsigned NUM_WARPS = 8;
  localparam int unsigned NUM_PREGS = 16;
  localparam int unsigned PR_ADDR_W = $clog2(NUM_PREGS);
  localparam int unsigned WARP_W    = $clog2(NUM_WARPS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } pie_state_t;

endpackage

// File: rtl/predicate_init_engine.sv
// Fills every predicate register of one warp with a value on the selected
// lanes, then optionally reads each register back and flags the first mismatch.
module predicate_init_engine
  import predicate_pkg::*;
#(
  parameter int unsigned NUM_LANES = predicate_pkg::NUM_LANES,
  parameter int unsigned NUM_WARPS = predicate_pkg::NUM_WARPS,
  parameter int unsigned NUM_PREGS = predicate_pkg::NUM_PREGS,
  parameter bit          VERIFY    = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [$clog2(NUM_WARPS)-1:0] req_warp,
  input  logic [NUM_LANES-1:0]         req_lane_mask,
  input  logic                         req_value,
  output logic                         done_valid,
  output logic                         done_error,
  output logic [$clog2(NUM_PREGS)-1:0] done_err_addr,
  input  logic                         pr_grant,
  output logic [$clog2(NUM_WARPS)-1:0] pr_warp_selector,
  output logic [NUM_LANES-1:0]         pr_write_en,
  output logic [$clog2(NUM_PREGS)-1:0] pr_waddr,
  output logic [NUM_LANES-1:0]         pr_wdata,
  output logic [NUM_LANES-1:0]         pr_read_en_0,
  output logic [$clog2(NUM_PREGS)-1:0] pr_raddr_0,
  input  logic [NUM_LANES-1:0]         pr_rdata_0
);

  localparam int unsigned AW = $clog2(NUM_PREGS);
  localparam int unsigned WW = $clog2(NUM_WARPS);

  pie_state_t            state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  logic [WW-1:0]         warp_q;
  logic [NUM_LANES-1:0]  mask_q;
  logic                  value_q;
  logic                  err_q, err_d;
  logic [AW-1:0]         err_addr_q, err_addr_d;
  logic                  accept;

  logic                  last_addr;
  logic [NUM_LANES-1:0]  fill;
  logic                  mismatch;

  assign last_addr = (cnt_q == AW'(NUM_PREGS - 1));
  assign fill      = {NUM_LANES{value_q}};
  assign mismatch  = |((pr_rdata_0 ^ fill) & mask_q);

  assign pr_warp_selector = warp_q;
  assign done_error       = err_q;
  assign done_err_addr    = err_addr_q;

  // State, counter, request latch and error capture registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      warp_q     <= '0;
      mask_q     <= '0;
      value_q    <= 1'b0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
      if (accept) begin
        warp_q  <= req_warp;
        mask_q  <= req_lane_mask;
        value_q <= req_value;
      end
    end
  end

  // Next-state, counter advance, port driving and read-back compare.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    err_d        = err_q;
    err_addr_d   = err_addr_q;
    accept       = 1'b0;
    req_ready    = 1'b0;
    done_valid   = 1'b0;
    pr_write_en  = '0;
    pr_waddr     = '0;
    pr_wdata     = '0;
    pr_read_en_0 = '0;
    pr_raddr_0   = '0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept     = 1'b1;
          cnt_d      = '0;
          err_d      = 1'b0;
          err_addr_d = '0;
          state_d    = (req_lane_mask == '0) ? ST_DONE : ST_WRITE;
        end
      end

      ST_WRITE: begin
        // Counter only moves on granted cycles so no address is skipped.
        if (pr_grant) begin
          pr_write_en = mask_q;
          pr_waddr    = cnt_q;
          pr_wdata    = fill;
          cnt_d       = cnt_q + AW'(1);
          if (last_addr) begin
            state_d = VERIFY ? ST_VERIFY : ST_DONE;
          end
        end
      end

      ST_VERIFY: begin
        pr_read_en_0 = mask_q;
        pr_raddr_0   = cnt_q;
        cnt_d        = cnt_q + AW'(1);
        // Only the first failing address is reported.
        if (mismatch && !err_q) begin
          err_d      = 1'b1;
          err_addr_d = cnt_q;
        end
        if (last_addr) begin
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        done_valid = 1'b1;
        state_d    = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_predicate_init_engine.sv
// Bench for predicate_init_engine: register-file model, write/read scoreboards,
// vector table plus reset-abort sequence.
module tb_predicate_init_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_warp;
  logic [7:0] req_lane_mask;
  logic       req_value;
  logic       done_valid;
  logic       done_error;
  logic [3:0] done_err_addr;
  logic       pr_grant;
  logic [2:0] pr_warp_selector;
  logic [7:0] pr_write_en;
  logic [3:0] pr_waddr;
  logic [7:0] pr_wdata;
  logic [7:0] pr_read_en_0;
  logic [3:0] pr_raddr_0;
  logic [7:0] pr_rdata_0;

  always #5 clk = ~clk;

  predicate_init_engine dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_warp        (req_warp),
    .req_lane_mask   (req_lane_mask),
    .req_value       (req_value),
    .done_valid      (done_valid),
    .done_error      (done_error),
    .done_err_addr   (done_err_addr),
    .pr_grant        (pr_grant),
    .pr_warp_selector(pr_warp_selector),
    .pr_write_en     (pr_write_en),
    .pr_waddr        (pr_waddr),
    .pr_wdata        (pr_wdata),
    .pr_read_en_0    (pr_read_en_0),
    .pr_raddr_0      (pr_raddr_0),
    .pr_rdata_0      (pr_rdata_0)
  );

  int checks = 0;
  int errors = 0;

  // Predicate register file model: mem[warp][reg], bit i is lane i.
  logic [7:0] mem [8][16];
  logic       mem_clr;
  logic       fault_en;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int w = 0; w < 8; w++)
        for (int r = 0; r < 16; r++)
          mem[w][r] <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++)
        if (pr_write_en[i]) mem[pr_warp_selector][pr_waddr][i] <= pr_wdata[i];
    end
  end

  always_comb begin
    pr_rdata_0 = mem[pr_warp_selector][pr_raddr_0];
    if (fault_en && (pr_raddr_0 == 4'd9 || pr_raddr_0 == 4'd12))
      pr_rdata_0[3] = 1'b0;
  end

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] en;
    logic [7:0] data;
    logic [2:0] warp;
  } wr_t;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] en;
    logic [2:0] warp;
  } rd_t;

  wr_t wq[$];
  rd_t rq[$];
  wr_t we;
  rd_t re;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every write/read the DUT issues must match the next expected one.
  always @(negedge clk) begin
    if (!rst) begin
      if (pr_write_en != 8'h00) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write addr=%0d en=%h", pr_waddr, pr_write_en);
        end else begin
          we = wq.pop_front();
          if ({pr_waddr, pr_write_en, pr_wdata, pr_warp_selector, pr_grant} !==
              {we.addr, we.en, we.data, we.warp, 1'b1}) begin
            errors++;
            $display("FAIL write_beat actual addr=%0d en=%h data=%h warp=%0d grant=%b expected addr=%0d en=%h data=%h warp=%0d grant=1",
                     pr_waddr, pr_write_en, pr_wdata, pr_warp_selector, pr_grant,
                     we.addr, we.en, we.data, we.warp);
          end
        end
      end
      if (pr_read_en_0 != 8'h00) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_read addr=%0d en=%h", pr_raddr_0, pr_read_en_0);
        end else begin
          re = rq.pop_front();
          if ({pr_raddr_0, pr_read_en_0, pr_warp_selector, pr_write_en} !==
              {re.addr, re.en, re.warp, 8'h00}) begin
            errors++;
            $display("FAIL read_beat actual addr=%0d en=%h warp=%0d wen=%h expected addr=%0d en=%h warp=%0d wen=00",
                     pr_raddr_0, pr_read_en_0, pr_warp_selector, pr_write_en,
                     re.addr, re.en, re.warp);
          end
        end
      end
    end
  end

  typedef struct {
    logic [2:0] warp;
    logic [7:0] mask;
    logic       value;
    logic       throttle;
    logic       fault;
    logic       exp_err;
    logic [3:0] exp_addr;
    int         exp_lat;
    logic [7:0] exp_mem;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] w, input logic [7:0] m, input logic v,
                              input logic th, input logic f, input logic ee,
                              input logic [3:0] ea, input int lat, input logic [7:0] em);
    vec_t t;
    t.warp = w; t.mask = m; t.value = v; t.throttle = th; t.fault = f;
    t.exp_err = ee; t.exp_addr = ea; t.exp_lat = lat; t.exp_mem = em;
    return t;
  endfunction

  task automatic push_expect(input logic [2:0] w, input logic [7:0] m, input logic v);
    if (m != 8'h00) begin
      for (int a = 0; a < 16; a++) begin
        wq.push_back('{addr: 4'(a), en: m, data: {8{v}}, warp: w});
        rq.push_back('{addr: 4'(a), en: m, warp: w});
      end
    end
  endtask

  // Issue one request, wait for completion, check result, latency and memory.
  task automatic run_vec(input vec_t v);
    int  n;
    bit  seen;
    @(posedge clk); #1;
    fault_en      = v.fault;
    req_valid     = 1'b1;
    req_warp      = v.warp;
    req_lane_mask = v.mask;
    req_value     = v.value;
    push_expect(v.warp, v.mask, v.value);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      pr_grant = v.throttle ? (n % 2 == 1) : 1'b1;
      @(negedge clk);
      if (done_valid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("done_latency", 32'(n), 32'(v.exp_lat));
    chk("done_error", 32'(done_error), 32'(v.exp_err));
    chk("done_err_addr", 32'(done_err_addr), 32'(v.exp_addr));
    chk("ready_low_in_done", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    chk("ready_after_done", 32'(req_ready), 32'd1);
    chk("done_one_cycle", 32'(done_valid), 32'd0);
    chk("warp_sel_held", 32'(pr_warp_selector), 32'(v.warp));
    chk("writes_left", 32'(wq.size()), 32'd0);
    chk("reads_left", 32'(rq.size()), 32'd0);
    fault_en = 1'b0;
    pr_grant = 1'b1;
    for (int r = 0; r < 16; r++)
      chk($sformatf("mem_w%0d_r%0d", v.warp, r), 32'(mem[v.warp][r]), 32'(v.exp_mem));
  endtask

  vec_t vecs[8];
  bit   hit;

  initial begin
    rst = 1'b1; mem_clr = 1'b1; fault_en = 1'b0;
    req_valid = 1'b0; req_warp = '0; req_lane_mask = '0; req_value = 1'b0;
    pr_grant = 1'b1;

    vecs[0] = mk(3'd5, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32, 8'hFF);
    vecs[1] = mk(3'd2, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 32, 8'hFF);
    vecs[2] = mk(3'd2, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32, 8'hF0);
    vecs[3] = mk(3'd3, 8'hAA, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 48, 8'hAA);
    vecs[4] = mk(3'd1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 4'd9, 32, 8'hFF);
    vecs[5] = mk(3'd6, 8'hF7, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 32, 8'hF7);
    vecs[6] = mk(3'd4, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 0,  8'h00);
    vecs[7] = mk(3'd0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 48, 8'h80);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_done_valid", 32'(done_valid), 32'd0);
    chk("rst_done_error", 32'(done_error), 32'd0);
    chk("rst_done_err_addr", 32'(done_err_addr), 32'd0);
    chk("rst_warp_sel", 32'(pr_warp_selector), 32'd0);
    chk("rst_write_bus", {8'h00, pr_write_en, pr_wdata, 4'h0, pr_waddr}, 32'd0);
    chk("rst_read_bus", {20'h0, pr_read_en_0, pr_raddr_0}, 32'd0);
    mem_clr = 1'b0;
    rst = 1'b0;

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // Abort a full fill with reset while address 6 is on the write port.
    @(posedge clk); #1;
    req_valid = 1'b1; req_warp = 3'd7; req_lane_mask = 8'hFF; req_value = 1'b1;
    pr_grant = 1'b1;
    push_expect(3'd7, 8'hFF, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 40 && !hit; k++) begin
      @(negedge clk);
      if (pr_write_en != 8'h00 && pr_waddr == 4'd6) hit = 1'b1;
    end
    chk("abort_reached_addr6", 32'(hit), 32'd1);
    rst = 1'b1;
    wq.delete();
    rq.delete();
    #1;
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_write_bus", {8'h00, pr_write_en, pr_wdata, 4'h0, pr_waddr}, 32'd0);
    chk("abort_read_bus", {20'h0, pr_read_en_0, pr_raddr_0}, 32'd0);
    chk("abort_done_valid", 32'(done_valid), 32'd0);
    chk("abort_warp_sel", 32'(pr_warp_selector), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_mem_r5_written", 32'(mem[7][5]), 32'hFF);
    chk("abort_mem_r6_not_written", 32'(mem[7][6]), 32'h00);
    run_vec(mk(3'd7, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32, 8'h00));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
